// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: character width and the
// launch FSM encoding used by the transmit buffer.
package uart_pkg;

  // Character width shared by the buffer, transmit controller and serializer.
  localparam int UART_DATA_WIDTH = 8;

  typedef logic [1:0] launch_state_t;

  localparam logic [1:0] L_IDLE      = 2'd0;
  localparam logic [1:0] L_WAIT_BUSY = 2'd1;
  localparam logic [1:0] L_WAIT_DONE = 2'd2;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO feeding the UART launch FSM. Full/empty come from the
// registered occupancy count, so wr_en has no combinational path to them.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  wr_accept;
  logic                  rd_accept;

  assign full      = (count_q == FULL_COUNT);
  assign empty     = (count_q == '0);
  assign wr_accept = wr_en && !full;
  assign rd_accept = pop && !empty;

  assign rd_data  = mem[rd_ptr_q];
  assign count    = count_q;
  assign overflow = overflow_q;

  always_comb begin
    // NOTE: every signal gets its hold value first, so no branch can leave it unassigned and infer a latch.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    // DEPTH is a power of two, so the pointers wrap to 0 by plain overflow.
    if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_accept) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_en && full) overflow_d = 1'b1;

    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: storage is not reset; a zero count already makes its contents unreachable, and an unreset array maps to RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Transmit buffer ahead of the UART controller: queues host bytes and launches
// one at a time, waiting for busy to rise and fall before the next launch.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  input  logic                  busy,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  valid_data
);

  launch_state_t         state_q, state_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  valid_data_q, valid_data_d;
  logic                  pop;
  logic [DATA_WIDTH-1:0] rd_data;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .pop      (pop),
    .rd_data  (rd_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  always_comb begin
    state_d      = state_q;
    p_data_d     = p_data_q;
    valid_data_d = 1'b0;
    pop          = 1'b0;

    case (state_q)
      L_IDLE: begin
        if (!empty && !busy) begin
          p_data_d     = rd_data;
          pop          = 1'b1;
          valid_data_d = 1'b1;
          state_d      = L_WAIT_BUSY;
        end
      end
      // The controller raises busy a couple of cycles after the pulse; never
      // relaunch until that frame has visibly started and finished.
      L_WAIT_BUSY: begin
        if (busy) state_d = L_WAIT_DONE;
      end
      L_WAIT_DONE: begin
        if (!busy) state_d = L_IDLE;
      end
      default: state_d = L_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= L_IDLE;
      p_data_q     <= '0;
      valid_data_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      p_data_q     <= p_data_d;
      valid_data_q <= valid_data_d;
    end
  end

  // p_data stays put between launches; serializer and parity read it all frame.
  assign p_data     = p_data_q;
  assign valid_data = valid_data_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer: a busy model mimics the transmit
// controller and a scoreboard tracks every accepted byte until it launches.
module tb_uart_tx_buffer;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          busy;
  logic [DW-1:0] p_data;
  logic          valid_data;

  uart_tx_buffer #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .busy       (busy),
    .p_data     (p_data),
    .valid_data (valid_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: bytes the FIFO should hold, in launch order.
  logic [DW-1:0] sb [$];

  // Controller model: busy rises two cycles after the launch pulse and stays
  // high for busy_len cycles (or a random length when rand_len is set).
  logic busy_hold  = 1'b0;
  logic busy_model = 1'b0;
  int   busy_len   = 11;
  bit   rand_len   = 1'b0;
  int   dly        = 0;
  int   run        = 0;

  assign busy = busy_hold | busy_model;

  always @(negedge clk) begin
    if (!rst) begin
      busy_model = 1'b0;
      dly        = 0;
      run        = 0;
    end else begin
      if (run > 0) begin
        run--;
        if (run == 0) busy_model = 1'b0;
      end
      if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          busy_model = 1'b1;
          run        = rand_len ? int'($urandom_range(1, 12)) : busy_len;
        end
      end
      if (valid_data) dly = 2;
    end
  end

  // Monitor, sampled 1 time unit after every rising edge.
  logic [DW-1:0] p_last     = '0;
  bit            prev_valid = 1'b0;
  bit            launched   = 1'b0;
  bit            armed      = 1'b0;
  bit            pend       = 1'b0;
  int            low_cnt    = 0;

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      p_last     = '0;
      prev_valid = 1'b0;
      launched   = 1'b0;
      armed      = 1'b0;
      low_cnt    = 0;
    end else begin
      if (busy) low_cnt = 0;
      else low_cnt++;
      if (busy_hold) armed = 1'b0;
      // Busy fell at the previous edge: the FSM returns to idle there and must
      // launch on the next edge exactly when the FIFO was non-empty.
      if (armed && low_cnt == 2) begin
        check("launch_after_busy_fall", {31'b0, valid_data}, {31'b0, pend});
        armed = 1'b0;
      end
      if (valid_data) begin
        check("valid_one_cycle", {31'b0, prev_valid}, 32'd0);
        check("launch_has_data", {31'b0, (sb.size() != 0)}, 32'd1);
        if (sb.size() != 0) check("p_data_order", {24'b0, p_data}, {24'b0, sb.pop_front()});
        launched = 1'b1;
        p_last   = p_data;
      end else begin
        check("p_data_hold", {24'b0, p_data}, {24'b0, p_last});
      end
      if (low_cnt == 1) pend = (sb.size() != 0);
      if (launched && busy_model) begin
        armed    = 1'b1;
        launched = 1'b0;
      end
      check("count", {27'b0, count}, sb.size());
      check("empty", {31'b0, empty}, {31'b0, (sb.size() == 0)});
      check("full", {31'b0, full}, {31'b0, (sb.size() == DEPTH)});
      prev_valid = valid_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Drives one write for one edge; returns 1 unit after that edge.
  task automatic write_byte(input logic [DW-1:0] d, input bit accept);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
    if (accept) sb.push_back(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (valid_data) break;
    end
    check(name, {31'b0, valid_data}, 32'd1);
  endtask

  task automatic wait_drain();
    int idle = 0;
    for (int i = 0; i < 3000 && idle < 4; i++) begin
      tick();
      if (sb.size() == 0 && !busy && dly == 0 && !valid_data) idle++;
      else idle = 0;
    end
    check("drain_done", {31'b0, (idle >= 4)}, 32'd1);
  endtask

  typedef struct {
    logic [DW-1:0] data;
    bit            accept;
    logic [AW:0]   exp_count;
    logic          exp_full;
    logic          exp_ovf;
  } vec_t;

  vec_t          vecs [DEPTH+2];
  logic [DW-1:0] b2b  [3];

  initial begin
    for (int i = 0; i < DEPTH + 2; i++) begin
      vecs[i].data      = DW'(i);
      vecs[i].accept    = (i < DEPTH);
      vecs[i].exp_count = (i < DEPTH) ? (AW + 1)'(i + 1) : (AW + 1)'(DEPTH);
      vecs[i].exp_full  = (i >= DEPTH - 1);
      vecs[i].exp_ovf   = (i >= DEPTH);
    end
    b2b[0] = 8'h11;
    b2b[1] = 8'h22;
    b2b[2] = 8'h33;

    wr_en   = 1'b0;
    wr_data = '0;
    rst     = 1'b1;
    #1 rst  = 1'b0;
    #2;
    check("rst_count", {27'b0, count}, 32'd0);
    check("rst_empty", {31'b0, empty}, 32'd1);
    check("rst_full", {31'b0, full}, 32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    check("rst_valid", {31'b0, valid_data}, 32'd0);
    check("rst_p_data", {24'b0, p_data}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (2) tick();

    // Single byte: empty visible for one cycle, then a one-cycle launch.
    write_byte(8'hA5, 1'b1);
    #1;
    check("single_no_early_launch", {31'b0, valid_data}, 32'd0);
    check("single_count", {27'b0, count}, 32'd1);
    tick();
    check("single_launch", {31'b0, valid_data}, 32'd1);
    check("single_p_data", {24'b0, p_data}, 32'h0000_00A5);
    tick();
    check("single_pulse_width", {31'b0, valid_data}, 32'd0);
    for (int i = 0; i < 40 && !busy; i++) tick();
    check("single_busy_rose", {31'b0, busy}, 32'd1);
    for (int i = 0; i < 40 && busy; i++) begin
      check("single_hold_in_frame", {24'b0, p_data}, 32'h0000_00A5);
      tick();
    end
    wait_drain();

    // Back-to-back: three queued bytes drain in order, count 3 -> 2 -> 1 -> 0.
    @(negedge clk) busy_hold = 1'b1;
    for (int i = 0; i < 3; i++) write_byte(b2b[i], 1'b1);
    #1;
    check("b2b_count_queued", {27'b0, count}, 32'd3);
    @(negedge clk) busy_hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_valid("b2b_launch");
      check("b2b_p_data", {24'b0, p_data}, {24'b0, b2b[i]});
      check("b2b_count", {27'b0, count}, 32'(2 - i));
    end
    wait_drain();

    // Full/overflow: busy held, DEPTH+2 writes, last two dropped.
    @(negedge clk) busy_hold = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      write_byte(vecs[i].data, vecs[i].accept);
      #1;
      check("fill_count", {27'b0, count}, {27'b0, vecs[i].exp_count});
      check("fill_full", {31'b0, full}, {31'b0, vecs[i].exp_full});
      check("fill_overflow", {31'b0, overflow}, {31'b0, vecs[i].exp_ovf});
    end
    @(negedge clk) busy_hold = 1'b0;
    wait_drain();
    check("overflow_sticky", {31'b0, overflow}, 32'd1);
    check("fill_last_byte", {24'b0, p_data}, 32'(DEPTH - 1));

    // Write on the launch edge at count 1: count stays 1, byte launches next.
    @(negedge clk) busy_hold = 1'b1;
    write_byte(8'h55, 1'b1);
    @(negedge clk);
    busy_hold = 1'b0;
    wr_en     = 1'b1;
    wr_data   = 8'h7E;
    sb.push_back(8'h7E);
    @(posedge clk);
    #1 wr_en = 1'b0;
    #1;
    check("simul_launch", {31'b0, valid_data}, 32'd1);
    check("simul_count", {27'b0, count}, 32'd1);
    check("simul_p_data", {24'b0, p_data}, 32'h0000_0055);
    wait_valid("simul_second_launch");
    check("simul_second_p_data", {24'b0, p_data}, 32'h0000_007E);
    wait_drain();

    // Pointer wrap: 40 bytes with random gaps and random frame lengths.
    rand_len = 1'b1;
    for (int i = 0; i < 40; i++) begin
      for (int g = 0; g < 500 && sb.size() >= DEPTH - 2; g++) tick();
      write_byte(DW'(8'h80 + i), 1'b1);
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_drain();
    rand_len = 1'b0;

    // Asynchronous reset mid-operation with five bytes queued.
    @(negedge clk) busy_hold = 1'b1;
    for (int i = 0; i < 5; i++) write_byte(DW'(8'hC1 + i), 1'b1);
    #2;
    rst       = 1'b0;
    busy_hold = 1'b0;
    sb.delete();
    #1;
    check("arst_count", {27'b0, count}, 32'd0);
    check("arst_empty", {31'b0, empty}, 32'd1);
    check("arst_valid", {31'b0, valid_data}, 32'd0);
    check("arst_p_data", {24'b0, p_data}, 32'd0);
    check("arst_overflow", {31'b0, overflow}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("no_launch_after_reset", {31'b0, valid_data}, 32'd0);
    end
    write_byte(8'h3C, 1'b1);
    wait_valid("post_reset_launch");
    check("post_reset_p_data", {24'b0, p_data}, 32'h0000_003C);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d / mismatched %0d", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
